// File: rtl/bram_reader_pkg.sv
// Shared types and sizing for the block-RAM stream reader.
package bram_reader_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  localparam int unsigned FIFO_DEPTH   = 4;
  localparam int unsigned MAX_INFLIGHT = 2;
  localparam int unsigned CNT_W        = $clog2(FIFO_DEPTH + 1);

endpackage

// File: rtl/bram_reader_fifo.sv
// Small synchronous FIFO holding {last, data} beats; head is read straight from storage.
module bram_reader_fifo
  import bram_reader_pkg::*;
#(
  parameter int unsigned WIDTH = 33
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_head,
  output logic             o_empty,
  output logic [CNT_W-1:0] o_count
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);

  logic [WIDTH-1:0] r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;

  // Storage is cleared on reset so the head (and thus OUT_DATA) reads zero.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
        r_mem[i] <= '0;
      end
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) begin
        r_mem[r_wr_ptr] <= i_data;
        r_wr_ptr        <= r_wr_ptr + 1'b1;
      end
      if (i_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_head  = r_mem[r_rd_ptr];
  assign o_empty = (r_count == '0);
  assign o_count = r_count;

endmodule

// File: rtl/bram_stream_reader.sv
// Issues credit-limited reads to a one-cycle block RAM and streams the words out with a last flag.
module bram_stream_reader
  import bram_reader_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 9
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic                  CMD_VALID,
  output logic                  CMD_READY,
  input  logic [ADDR_WIDTH-1:0] CMD_ADDR,
  input  logic [ADDR_WIDTH:0]   CMD_LEN,
  output logic                  RAM_RE,
  output logic [ADDR_WIDTH-1:0] RAM_RD_ADDR,
  input  logic [DATA_WIDTH-1:0] RAM_DO,
  input  logic                  RAM_DO_VALID,
  output logic                  OUT_VALID,
  input  logic                  OUT_READY,
  output logic [DATA_WIDTH-1:0] OUT_DATA,
  output logic                  OUT_LAST,
  output logic                  DONE
);

  localparam logic [ADDR_WIDTH:0] LEN_ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};

  state_t                r_state;
  state_t                w_state_nxt;
  logic [ADDR_WIDTH-1:0] r_issue_addr;
  logic [ADDR_WIDTH:0]   r_remaining;
  logic [1:0]            r_inflight;
  logic                  r_ram_re;
  logic [ADDR_WIDTH-1:0] r_ram_rd_addr;
  logic                  r_done;

  logic                  w_cmd_fire;
  logic                  w_issue;
  logic                  w_exit;
  logic                  w_rd_ret;
  logic                  w_push_last;
  logic                  w_pop;
  logic                  w_fifo_empty;
  logic [CNT_W-1:0]      w_fifo_count;
  logic [CNT_W:0]        w_credit_used;
  logic [DATA_WIDTH:0]   w_head;

  assign CMD_READY     = (r_state == ST_IDLE);
  assign w_cmd_fire    = CMD_VALID && CMD_READY;
  assign w_credit_used = (CNT_W+1)'(w_fifo_count) + (CNT_W+1)'(r_inflight);
  // Returns with nothing outstanding (e.g. reads issued before a reset) are dropped.
  assign w_rd_ret      = RAM_DO_VALID && (r_inflight != '0);
  // All reads are issued once in DRAIN, so the sole outstanding read is the final one.
  assign w_push_last   = (r_state == ST_DRAIN) && (r_inflight == 2'd1);
  assign w_pop         = OUT_VALID && OUT_READY;

  // A zero-length command passes through DRAIN with nothing queued, which
  // drops CMD_READY for one cycle and lets DONE pulse the cycle after.
  always_comb begin
    w_state_nxt = r_state;
    w_issue     = 1'b0;
    w_exit      = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (w_cmd_fire) begin
          w_state_nxt = (CMD_LEN == '0) ? ST_DRAIN : ST_RUN;
        end
      end
      ST_RUN: begin
        w_issue = (r_remaining != '0) &&
                  (w_credit_used < (CNT_W+1)'(FIFO_DEPTH));
        if (w_issue && (r_remaining == LEN_ONE)) begin
          w_state_nxt = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        w_exit = (w_pop && w_head[DATA_WIDTH]) ||
                 (w_fifo_empty && (r_inflight == '0));
        if (w_exit) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state       <= ST_IDLE;
      r_issue_addr  <= '0;
      r_remaining   <= '0;
      r_inflight    <= '0;
      r_ram_re      <= 1'b0;
      r_ram_rd_addr <= '0;
      r_done        <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_ram_re <= w_issue;
      r_done   <= w_exit;
      if (w_cmd_fire) begin
        r_issue_addr <= CMD_ADDR;
        r_remaining  <= CMD_LEN;
      end else if (w_issue) begin
        r_issue_addr <= r_issue_addr + 1'b1;
        r_remaining  <= r_remaining - 1'b1;
      end
      if (w_issue) begin
        r_ram_rd_addr <= r_issue_addr;
      end
      case ({w_issue, w_rd_ret})
        2'b10:   r_inflight <= r_inflight + 1'b1;
        2'b01:   r_inflight <= r_inflight - 1'b1;
        default: r_inflight <= r_inflight;
      endcase
    end
  end

  bram_reader_fifo #(
    .WIDTH (DATA_WIDTH + 1)
  ) u_fifo (
    .i_clk   (CLK),
    .i_rst_n (RST_N),
    .i_push  (w_rd_ret),
    .i_data  ({w_push_last, RAM_DO}),
    .i_pop   (w_pop),
    .o_head  (w_head),
    .o_empty (w_fifo_empty),
    .o_count (w_fifo_count)
  );

  assign RAM_RE      = r_ram_re;
  assign RAM_RD_ADDR = r_ram_rd_addr;
  assign OUT_VALID   = !w_fifo_empty;
  assign OUT_DATA    = w_head[DATA_WIDTH-1:0];
  assign OUT_LAST    = w_head[DATA_WIDTH];
  assign DONE        = r_done;

endmodule

// File: tb/tb_bram_stream_reader.sv
// Scoreboard bench for bram_stream_reader: a behavioural RAM, expected beats/addresses
// queued at command time, and a negedge monitor that checks every handshake.
module tb_bram_stream_reader;

  localparam int unsigned DW    = 32;
  localparam int unsigned AW    = 9;
  localparam int unsigned DEPTH = 512;

  typedef struct packed {
    logic          last;
    logic [DW-1:0] data;
  } beat_t;

  logic          CLK = 1'b0;
  logic          RST_N;
  logic          CMD_VALID;
  logic          CMD_READY;
  logic [AW-1:0] CMD_ADDR;
  logic [AW:0]   CMD_LEN;
  logic          RAM_RE;
  logic [AW-1:0] RAM_RD_ADDR;
  logic [DW-1:0] RAM_DO;
  logic          RAM_DO_VALID;
  logic          OUT_VALID;
  logic          OUT_READY;
  logic [DW-1:0] OUT_DATA;
  logic          OUT_LAST;
  logic          DONE;

  always #5 CLK = ~CLK;

  bram_stream_reader #(
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW)
  ) dut (
    .CLK          (CLK),
    .RST_N        (RST_N),
    .CMD_VALID    (CMD_VALID),
    .CMD_READY    (CMD_READY),
    .CMD_ADDR     (CMD_ADDR),
    .CMD_LEN      (CMD_LEN),
    .RAM_RE       (RAM_RE),
    .RAM_RD_ADDR  (RAM_RD_ADDR),
    .RAM_DO       (RAM_DO),
    .RAM_DO_VALID (RAM_DO_VALID),
    .OUT_VALID    (OUT_VALID),
    .OUT_READY    (OUT_READY),
    .OUT_DATA     (OUT_DATA),
    .OUT_LAST     (OUT_LAST),
    .DONE         (DONE)
  );

  // One-cycle RAM: data and valid appear the cycle after the read enable, zero otherwise.
  logic [DW-1:0] mem [DEPTH];
  initial begin
    RAM_DO       = '0;
    RAM_DO_VALID = 1'b0;
  end
  always @(posedge CLK) begin
    RAM_DO_VALID <= RAM_RE;
    RAM_DO       <= RAM_RE ? mem[RAM_RD_ADDR] : '0;
  end

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  beat_t         exp_q[$];
  logic [AW-1:0] addr_q[$];

  int    re_total   = 0;
  int    ov_total   = 0;
  int    beat_total = 0;
  int    done_total = 0;
  int    done_cyc   = 0;
  int    beat_cyc [4096];
  logic  held       = 1'b0;
  beat_t held_beat;

  // Monitor: samples on the falling edge, away from the active edge.
  initial begin
    beat_t e;
    forever begin
      @(negedge CLK);
      if (!RST_N) begin
        held = 1'b0;
      end else begin
        chk("credit_bound", 64'(int'(dut.u_fifo.r_count) + int'(dut.r_inflight) <= 4), 64'd1);
        if (RAM_RE) begin
          re_total++;
          if (addr_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL ram_addr: unexpected read of 0x%0h, none required", RAM_RD_ADDR);
          end else begin
            chk("ram_addr", 64'(RAM_RD_ADDR), 64'(addr_q.pop_front()));
          end
        end
        if (OUT_VALID) begin
          ov_total++;
          if (held) begin
            chk("hold_data", 64'(OUT_DATA), 64'(held_beat.data));
            chk("hold_last", 64'(OUT_LAST), 64'(held_beat.last));
          end
          if (OUT_READY) begin
            held = 1'b0;
            if (exp_q.size() == 0) begin
              checks++;
              errors++;
              $display("FAIL beat: extra beat 0x%0h, none required", OUT_DATA);
            end else begin
              e = exp_q.pop_front();
              chk("beat_data", 64'(OUT_DATA), 64'(e.data));
              chk("beat_last", 64'(OUT_LAST), 64'(e.last));
            end
            if (beat_total < 4096) beat_cyc[beat_total] = cyc;
            beat_total++;
          end else begin
            held      = 1'b1;
            held_beat = '{last: OUT_LAST, data: OUT_DATA};
          end
        end else begin
          held = 1'b0;
        end
        if (DONE) begin
          done_total++;
          done_cyc = cyc;
        end
      end
    end
  end

  logic rdy_rand  = 1'b0;
  logic rdy_fixed = 1'b1;
  initial begin
    OUT_READY = 1'b1;
    forever begin
      @(posedge CLK);
      #1;
      OUT_READY = rdy_rand ? 1'($urandom_range(0, 1)) : rdy_fixed;
    end
  end

  task automatic send_cmd(input int addr, input int len, output int e);
    beat_t         b;
    logic [AW-1:0] a;
    int            n;
    for (int i = 0; i < len; i++) begin
      a = AW'((addr + i) % DEPTH);
      addr_q.push_back(a);
      b.last = (i == len - 1);
      b.data = mem[a];
      exp_q.push_back(b);
    end
    @(negedge CLK);
    CMD_VALID = 1'b1;
    CMD_ADDR  = AW'(addr);
    CMD_LEN   = (AW+1)'(len);
    n = 0;
    while (!CMD_READY && n < 200) begin
      @(negedge CLK);
      n++;
    end
    if (n >= 200) begin
      $display("FAIL cmd_accept: CMD_READY stuck low, required high within 200 cycles");
      $fatal(1, "command never accepted");
    end
    @(posedge CLK);
    #1;
    e         = cyc;
    CMD_VALID = 1'b0;
    chk("cmd_ready_low_after_accept", 64'(CMD_READY), 64'd0);
  endtask

  task automatic wait_done(input int d0);
    int n;
    n = 0;
    while (done_total == d0 && n < 3000) begin
      @(posedge CLK);
      n++;
    end
    if (n >= 3000) begin
      checks++;
      errors++;
      $display("FAIL done_timeout: no DONE after 3000 cycles, required one");
    end
    repeat (3) @(posedge CLK);
    chk("beats_outstanding", 64'(exp_q.size()), 64'd0);
    chk("reads_outstanding", 64'(addr_q.size()), 64'd0);
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_cmd_ready"}, 64'(CMD_READY), 64'd1);
    chk({tag, "_ram_re"}, 64'(RAM_RE), 64'd0);
    chk({tag, "_ram_addr"}, 64'(RAM_RD_ADDR), 64'd0);
    chk({tag, "_out_valid"}, 64'(OUT_VALID), 64'd0);
    chk({tag, "_out_data"}, 64'(OUT_DATA), 64'd0);
    chk({tag, "_out_last"}, 64'(OUT_LAST), 64'd0);
    chk({tag, "_done"}, 64'(DONE), 64'd0);
  endtask

  initial begin
    int e, r0, b0, d0, o0, addr, len;
    void'($urandom(32'd20240611));
    for (int i = 0; i < int'(DEPTH); i++) mem[i] = DW'(i + 32'h100);
    RST_N     = 1'b0;
    CMD_VALID = 1'b0;
    CMD_ADDR  = '0;
    CMD_LEN   = '0;
    repeat (3) @(posedge CLK);
    #1;
    check_reset_values("reset");
    @(negedge CLK);
    RST_N = 1'b1;
    repeat (2) @(posedge CLK);

    // Basic LEN=4 with cycle-accurate latency.
    r0 = re_total; b0 = beat_total; d0 = done_total;
    send_cmd(5, 4, e);
    wait_done(d0);
    chk("basic_first_beat_cycle", 64'(beat_cyc[b0] - e), 64'd3);
    chk("basic_last_beat_cycle", 64'(beat_cyc[b0 + 3] - e), 64'd6);
    chk("basic_done_cycle", 64'(done_cyc - e), 64'd7);
    chk("basic_re_cycles", 64'(re_total - r0), 64'd4);
    chk("basic_done_count", 64'(done_total - d0), 64'd1);

    // Zero-length command.
    r0 = re_total; o0 = ov_total; d0 = done_total;
    send_cmd(7, 0, e);
    @(posedge CLK);
    #1;
    chk("len0_done_cycle1", 64'(DONE), 64'd1);
    chk("len0_ready_cycle1", 64'(CMD_READY), 64'd1);
    wait_done(d0);
    chk("len0_re_count", 64'(re_total - r0), 64'd0);
    chk("len0_out_valid_count", 64'(ov_total - o0), 64'd0);
    chk("len0_done_count", 64'(done_total - d0), 64'd1);

    // Address wrap at the top of the RAM.
    d0 = done_total; b0 = beat_total;
    send_cmd(510, 4, e);
    wait_done(d0);
    chk("wrap_beats", 64'(beat_total - b0), 64'd4);

    // Full stall bounds the reads in flight, then random backpressure.
    rdy_fixed = 1'b0;
    r0 = re_total; b0 = beat_total; d0 = done_total;
    send_cmd(37, 16, e);
    repeat (20) @(posedge CLK);
    chk("stall_re_count", 64'(re_total - r0), 64'd4);
    chk("stall_beats", 64'(beat_total - b0), 64'd0);
    rdy_rand = 1'b1;
    wait_done(d0);
    chk("bp_beats", 64'(beat_total - b0), 64'd16);
    chk("bp_done_count", 64'(done_total - d0), 64'd1);
    rdy_rand  = 1'b0;
    rdy_fixed = 1'b1;

    // Asynchronous reset in cycle 4 of a LEN=8 command.
    d0 = done_total;
    send_cmd(100, 8, e);
    repeat (4) @(posedge CLK);
    #2;
    RST_N = 1'b0;
    #1;
    check_reset_values("midreset");
    exp_q.delete();
    addr_q.delete();
    #1;
    RST_N = 1'b1;
    repeat (5) @(posedge CLK);
    chk("midreset_no_done", 64'(done_total - d0), 64'd0);
    b0 = beat_total; d0 = done_total;
    send_cmd(0, 2, e);
    wait_done(d0);
    chk("post_reset_beats", 64'(beat_total - b0), 64'd2);

    // Full-depth command.
    b0 = beat_total; d0 = done_total;
    send_cmd(0, 512, e);
    wait_done(d0);
    repeat (5) @(posedge CLK);
    chk("full_beats", 64'(beat_total - b0), 64'd512);
    chk("full_done_count", 64'(done_total - d0), 64'd1);

    // Random contents, commands and backpressure.
    for (int i = 0; i < int'(DEPTH); i++) mem[i] = $urandom;
    rdy_rand = 1'b1;
    for (int k = 0; k < 8; k++) begin
      addr = int'($urandom_range(0, DEPTH - 1));
      len  = int'($urandom_range(0, 40));
      b0 = beat_total; d0 = done_total;
      send_cmd(addr, len, e);
      wait_done(d0);
      chk("rand_beats", 64'(beat_total - b0), 64'(len));
      chk("rand_done_count", 64'(done_total - d0), 64'd1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
